sm4_tau_ctrl: RTL

SM4_TAU_CTRL -- requirements
Module: sm4_tau_ctrl

---
 rtl/sm4_tau_ctrl_if.sv | 26 ++
 rtl/sm4_tau_ctrl.sv | 74 +++++++
 2 files changed

// File: rtl/sm4_tau_ctrl_if.sv
// sm4_tau_ctrl_if: word handshake, result handshake and masked S-box byte port
interface sm4_tau_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y1;
  logic [31:0] out_y0;
  logic        err;
  logic        sb_start;
  logic [7:0]  sb_x;
  logic [7:0]  sb_m;
  logic        sb_finish;
  logic [7:0]  sb_y1;
  logic [7:0]  sb_y0;
  modport master (
    output in_valid, in_x, in_m, out_ready, sb_finish, sb_y1, sb_y0,
    input  in_ready, out_valid, out_y1, out_y0, err, sb_start, sb_x, sb_m
  );
  modport slave (
    input  in_valid, in_x, in_m, out_ready, sb_finish, sb_y1, sb_y0,
    output in_ready, out_valid, out_y1, out_y0, err, sb_start, sb_x, sb_m
  );
endinterface

// File: rtl/sm4_tau_ctrl.sv
// sm4_tau_ctrl: runs a masked 32-bit word through a byte S-box, one lane at a time MSB first
module sm4_tau_ctrl #(
  parameter int TIMEOUT = 31
) (
  input logic         clk,
  input logic         rst,
  sm4_tau_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      st, nxt;
  logic [1:0]  lane;
  logic [7:0]  cnt;
  logic [31:0] x_q, m_q, y1_q, y0_q;
  logic        err_q;
  logic        accept, fin, expire;
  assign accept = st == IDLE && bus.in_valid;
  assign fin    = st == WAIT && bus.sb_finish;
  assign expire = st == WAIT && !bus.sb_finish && cnt + 8'd1 == TO;
  // state register
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else     st <= nxt;
  // next-state: a finish on the last lane or a wait expiry ends the operation
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = bus.in_valid ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = fin ? (lane == 2'd0 ? DONE : ISSUE) : expire ? DONE : WAIT;
      DONE:    nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // outputs: handshakes decode the state, byte shares are gated to the lookup phase
  always_comb begin
    bus.in_ready  = st == IDLE;
    bus.out_valid = st == DONE;
    bus.sb_start  = st == ISSUE;
    bus.sb_x      = (st == ISSUE || st == WAIT) ? x_q[8*lane +: 8] : 8'h00;
    bus.sb_m      = (st == ISSUE || st == WAIT) ? m_q[8*lane +: 8] : 8'h00;
    bus.out_y1    = y1_q;
    bus.out_y0    = y0_q;
    bus.err       = err_q;
  end
  // datapath: latch shares, track lane and wait count, collect result bytes
  always_ff @(posedge clk)
    if (rst) begin
      lane  <= 2'd3;
      cnt   <= 8'd0;
      x_q   <= 32'd0;
      m_q   <= 32'd0;
      y1_q  <= 32'd0;
      y0_q  <= 32'd0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q   <= bus.in_x;
        m_q   <= bus.in_m;
        lane  <= 2'd3;
        y1_q  <= 32'd0;
        y0_q  <= 32'd0;
        err_q <= 1'b0;
      end
      if (st == ISSUE) cnt <= 8'd0;
      if (st == WAIT && !bus.sb_finish) cnt <= cnt + 8'd1;
      if (fin) begin
        y1_q[8*lane +: 8] <= bus.sb_y1;
        y0_q[8*lane +: 8] <= bus.sb_y0;
        if (lane != 2'd0) lane <= lane - 2'd1;
      end
      if (expire) err_q <= 1'b1;
    end
endmodule
